// File: rtl/io_input_conditioner_if.sv
// rtl/io_input_conditioner_if.sv - pin-side and LSU-side signals of the input conditioner
interface io_input_conditioner_if #(
   parameter int SW_W = 18
);
   logic [SW_W-1:0] sw_raw_i;
   logic [3:0]      btn_raw_i;
   logic [31:0]     io_sw_o;
   logic [3:0]      io_btn_o;
   logic [3:0]      btn_press_o;

   modport master (
      output sw_raw_i, btn_raw_i,
      input  io_sw_o, io_btn_o, btn_press_o
   );

   modport slave (
      input  sw_raw_i, btn_raw_i,
      output io_sw_o, io_btn_o, btn_press_o
   );
endinterface

// File: rtl/io_input_conditioner.sv
// rtl/io_input_conditioner.sv - synchronise switches/buttons, debounce buttons, emit press pulses
// Optional IO_SW_DEBOUNCE_EN adds the same debouncer to every switch bit.
module io_input_conditioner #(
   parameter int SW_W            = 18,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   io_input_conditioner_if.slave io
);
   localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]    BTN_IDLE = {4{BTN_ACTIVE_LOW}};

   logic [3:0]      btn_meta, btn_sync, btn_s;
   logic [3:0]      btn_q, btn_q_nxt;
   logic [3:0]      press_q, press_nxt;
   logic [CW-1:0]   btn_cnt     [4];
   logic [CW-1:0]   btn_cnt_nxt [4];
   logic [SW_W-1:0] sw_meta, sw_sync, sw_val;

   // Button sync flops reset to the released level so reset never looks like a press.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         btn_meta <= BTN_IDLE;
         btn_sync <= BTN_IDLE;
         sw_meta  <= '0;
         sw_sync  <= '0;
      end else begin
         btn_meta <= io.btn_raw_i;
         btn_sync <= btn_meta;
         sw_meta  <= io.sw_raw_i;
         sw_sync  <= sw_meta;
      end
   end

   assign btn_s = btn_sync ^ BTN_IDLE;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         btn_q   <= '0;
         press_q <= '0;
         for (int i = 0; i < 4; i++) btn_cnt[i] <= '0;
      end else begin
         btn_q   <= btn_q_nxt;
         press_q <= press_nxt;
         for (int i = 0; i < 4; i++) btn_cnt[i] <= btn_cnt_nxt[i];
      end
   end

   // PENDING while s differs from q; a revert clears the count, a full count commits.
   always_comb begin
      btn_q_nxt = btn_q;
      press_nxt = '0;
      for (int i = 0; i < 4; i++) begin
         btn_cnt_nxt[i] = '0;
         if (btn_s[i] != btn_q[i]) begin
            if (btn_cnt[i] == CNT_MAX) begin
               btn_q_nxt[i] = btn_s[i];
               press_nxt[i] = btn_s[i];
            end else begin
               btn_cnt_nxt[i] = btn_cnt[i] + CW'(1);
            end
         end
      end
   end

`ifdef IO_SW_DEBOUNCE_EN
   logic [SW_W-1:0] sw_q, sw_q_nxt;
   logic [CW-1:0]   sw_cnt     [SW_W];
   logic [CW-1:0]   sw_cnt_nxt [SW_W];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sw_q <= '0;
         for (int j = 0; j < SW_W; j++) sw_cnt[j] <= '0;
      end else begin
         sw_q <= sw_q_nxt;
         for (int j = 0; j < SW_W; j++) sw_cnt[j] <= sw_cnt_nxt[j];
      end
   end

   always_comb begin
      sw_q_nxt = sw_q;
      for (int j = 0; j < SW_W; j++) begin
         sw_cnt_nxt[j] = '0;
         if (sw_sync[j] != sw_q[j]) begin
            if (sw_cnt[j] == CNT_MAX) sw_q_nxt[j] = sw_sync[j];
            else                      sw_cnt_nxt[j] = sw_cnt[j] + CW'(1);
         end
      end
   end

   assign sw_val = sw_q;
`else
   assign sw_val = sw_sync;
`endif

   assign io.io_sw_o     = 32'(sw_val);
   assign io.io_btn_o    = btn_q;
   assign io.btn_press_o = press_q;
endmodule

// File: tb/tb_io_input_conditioner.sv
// tb/tb_io_input_conditioner.sv - directed and randomized checks of io_input_conditioner
module tb_io_input_conditioner;
   localparam int D    = 8;
   localparam int SW_W = 18;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   io_input_conditioner_if #(.SW_W(SW_W)) bus ();

   io_input_conditioner #(
      .SW_W(SW_W),
      .DEBOUNCE_CYCLES(D),
      .BTN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .io    (bus)
   );

   // Reference: two-stage delay line, then a bit adopts a new level once that level
   // has been seen D consecutive cycles in a row.
   logic [3:0]      mb1, mb2, mq, mpress, ms;
   logic [SW_W-1:0] mw1, mw2, mswq, msw;
   int              run    [4];
   int              sw_run [SW_W];

   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         mb1 = 4'hF; mb2 = 4'hF; mq = '0; mpress = '0;
         mw1 = '0;   mw2 = '0;   mswq = '0;
         for (int i = 0; i < 4; i++)    run[i] = 0;
         for (int j = 0; j < SW_W; j++) sw_run[j] = 0;
      end else begin
         ms     = ~mb2;
         msw    = mw2;
         mpress = '0;
         for (int i = 0; i < 4; i++) begin
            if (ms[i] === mq[i]) run[i] = 0;
            else begin
               run[i] = run[i] + 1;
               if (run[i] == D) begin
                  mq[i] = ms[i]; mpress[i] = ms[i]; run[i] = 0;
               end
            end
         end
`ifdef IO_SW_DEBOUNCE_EN
         for (int j = 0; j < SW_W; j++) begin
            if (msw[j] === mswq[j]) sw_run[j] = 0;
            else begin
               sw_run[j] = sw_run[j] + 1;
               if (sw_run[j] == D) begin mswq[j] = msw[j]; sw_run[j] = 0; end
            end
         end
`endif
         mb2 = mb1; mb1 = bus.btn_raw_i;
         mw2 = mw1; mw1 = bus.sw_raw_i;
`ifndef IO_SW_DEBOUNCE_EN
         mswq = mw2;
`endif
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.btn_raw_i = 4'h0;
      bus.sw_raw_i  = 18'h3FFFF;
      rst_n = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_cmp++;
         if (bus.io_sw_o !== 32'h0 || bus.io_btn_o !== 4'h0 || bus.btn_press_o !== 4'h0) begin
            n_bad++;
            $display("FAIL reset cyc %0d: sw=%h btn=%h press=%h required all 0",
                     k, bus.io_sw_o, bus.io_btn_o, bus.btn_press_o);
         end
      end
      bus.btn_raw_i = 4'hF;
      bus.sw_raw_i  = '0;
      rst_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_clean_press();
      logic [3:0] eb, ep;
      bus.btn_raw_i = 4'hE;
      for (int k = 1; k <= 11; k++) begin
         tick();
         eb = (k >= 10) ? 4'h1 : 4'h0;
         ep = (k == 10) ? 4'h1 : 4'h0;
         n_cmp++;
         if (bus.io_btn_o !== eb || bus.btn_press_o !== ep) begin
            n_bad++;
            $display("FAIL clean_press edge %0d: btn=%h press=%h required btn=%h press=%h",
                     k, bus.io_btn_o, bus.btn_press_o, eb, ep);
         end
      end
      bus.btn_raw_i = 4'hF;
      for (int k = 1; k <= 12; k++) begin
         tick();
         eb = (k >= 10) ? 4'h0 : 4'h1;
         n_cmp++;
         if (bus.io_btn_o !== eb || bus.btn_press_o !== 4'h0) begin
            n_bad++;
            $display("FAIL clean_release edge %0d: btn=%h press=%h required btn=%h press=0",
                     k, bus.io_btn_o, bus.btn_press_o, eb);
         end
      end
   endtask

   task automatic test_bounce();
      int         pulses = 0;
      logic [3:0] eb, ep;
      bus.btn_raw_i = 4'hD;
      repeat (5) begin
         tick();
         if (bus.btn_press_o !== 4'h0) pulses++;
         n_cmp++;
         if (bus.io_btn_o !== 4'h0) begin
            n_bad++; $display("FAIL bounce_low: btn=%h required 0", bus.io_btn_o);
         end
      end
      bus.btn_raw_i = 4'hF;
      repeat (2) begin
         tick();
         if (bus.btn_press_o !== 4'h0) pulses++;
         n_cmp++;
         if (bus.io_btn_o !== 4'h0) begin
            n_bad++; $display("FAIL bounce_high: btn=%h required 0", bus.io_btn_o);
         end
      end
      bus.btn_raw_i = 4'hD;
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (bus.btn_press_o !== 4'h0) pulses++;
         eb = (k >= 10) ? 4'h2 : 4'h0;
         ep = (k == 10) ? 4'h2 : 4'h0;
         n_cmp++;
         if (bus.io_btn_o !== eb || bus.btn_press_o !== ep) begin
            n_bad++;
            $display("FAIL bounce_final edge %0d: btn=%h press=%h required btn=%h press=%h",
                     k, bus.io_btn_o, bus.btn_press_o, eb, ep);
         end
      end
      n_cmp++;
      if (pulses !== 1) begin
         n_bad++; $display("FAIL bounce_pulse_count: got %0d required 1", pulses);
      end
      bus.btn_raw_i = 4'hF;
      repeat (12) tick();
   endtask

   task automatic test_glitch();
      bus.btn_raw_i = 4'hB;
      for (int k = 1; k <= 27; k++) begin
         if (k == 8) bus.btn_raw_i = 4'hF;
         tick();
         n_cmp++;
         if (bus.io_btn_o !== 4'h0 || bus.btn_press_o !== 4'h0) begin
            n_bad++;
            $display("FAIL glitch edge %0d: btn=%h press=%h required 0",
                     k, bus.io_btn_o, bus.btn_press_o);
         end
      end
   endtask

   task automatic test_switches();
      logic [31:0] es;
`ifdef IO_SW_DEBOUNCE_EN
      localparam int LAT = 10;
`else
      localparam int LAT = 2;
`endif
      bus.sw_raw_i = 18'h2A5A5;
      for (int k = 1; k <= LAT + 1; k++) begin
         tick();
         es = (k >= LAT) ? 32'h0002A5A5 : 32'h0;
         n_cmp++;
         if (bus.io_sw_o !== es) begin
            n_bad++;
            $display("FAIL switch_latency edge %0d: sw=%h required %h", k, bus.io_sw_o, es);
         end
      end
`ifdef IO_SW_DEBOUNCE_EN
      bus.sw_raw_i = 18'h15A5A;
      for (int k = 1; k <= 16; k++) begin
         if (k == 4) bus.sw_raw_i = 18'h2A5A5;
         tick();
         n_cmp++;
         if (bus.io_sw_o !== 32'h0002A5A5) begin
            n_bad++;
            $display("FAIL switch_glitch edge %0d: sw=%h required 0002a5a5", k, bus.io_sw_o);
         end
      end
`endif
   endtask

   task automatic test_reset_midcount();
      int         pulses = 0;
      logic [3:0] eb, ep;
      bus.btn_raw_i = 4'h7;
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.io_btn_o !== 4'h0 || bus.btn_press_o !== 4'h0) begin
         n_bad++; $display("FAIL midcount_in_reset: btn=%h press=%h required 0",
                           bus.io_btn_o, bus.btn_press_o);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (bus.btn_press_o !== 4'h0) pulses++;
         eb = (k >= 10) ? 4'h8 : 4'h0;
         ep = (k == 10) ? 4'h8 : 4'h0;
         n_cmp++;
         if (bus.io_btn_o !== eb || bus.btn_press_o !== ep) begin
            n_bad++;
            $display("FAIL midcount edge %0d: btn=%h press=%h required btn=%h press=%h",
                     k, bus.io_btn_o, bus.btn_press_o, eb, ep);
         end
      end
      bus.btn_raw_i = 4'hF;
      repeat (12) begin
         tick();
         if (bus.btn_press_o !== 4'h0) pulses++;
      end
      n_cmp++;
      if (pulses !== 1 || bus.io_btn_o !== 4'h0) begin
         n_bad++; $display("FAIL midcount_pulses: pulses=%0d btn=%h required 1 and 0",
                           pulses, bus.io_btn_o);
      end
   endtask

   task automatic test_async_reset();
      bus.btn_raw_i = 4'h0;
      repeat (12) tick();
      n_cmp++;
      if (bus.io_btn_o !== 4'hF) begin
         n_bad++; $display("FAIL async_pre: btn=%h required f", bus.io_btn_o);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.io_btn_o !== 4'h0 || bus.btn_press_o !== 4'h0 || bus.io_sw_o !== 32'h0) begin
         n_bad++; $display("FAIL async_reset: btn=%h press=%h sw=%h required 0",
                           bus.io_btn_o, bus.btn_press_o, bus.io_sw_o);
      end
      repeat (2) tick();
      bus.btn_raw_i = 4'hF;
      bus.sw_raw_i  = '0;
      rst_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_random();
      int hold;
      for (int n = 0; n < 80; n++) begin
         bus.btn_raw_i = 4'($urandom);
         bus.sw_raw_i  = SW_W'($urandom);
         hold = $urandom_range(1, 14);
         repeat (hold) begin
            tick();
            n_cmp++;
            if (bus.io_btn_o !== mq || bus.btn_press_o !== mpress || bus.io_sw_o !== 32'(mswq)) begin
               n_bad++;
               $display("FAIL random seg %0d: btn=%h press=%h sw=%h required btn=%h press=%h sw=%h",
                        n, bus.io_btn_o, bus.btn_press_o, bus.io_sw_o, mq, mpress, 32'(mswq));
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   initial begin
      bus.btn_raw_i = 4'h0;
      bus.sw_raw_i  = 18'h3FFFF;
      test_reset();
      test_clean_press();
      test_bounce();
      test_glitch();
      test_switches();
      test_reset_midcount();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Input conditioning stage that sits directly upstream of the load-store unit's input buffer. It takes raw board switches and push-buttons, synchronises them into `clk_i`, and debounces the buttons. It drives the 32-bit switch word and 4-bit button nibble that the LSU samples every cycle into its memory-mapped input region. It also emits one-cycle press pulses for use by interrupt or trace logic.

## Interface
Parameters:
- `SW_W`, 18: number of physical switches, 1..32.
- `DEBOUNCE_CYCLES`, 500000: stable cycles required before a debounced bit changes. This is 10 ms at 50 MHz. Minimum 2.
- `BTN_ACTIVE_LOW`, 1: 1 means raw buttons read 0 when pressed.

Ports:
- `clk_i`  in  1: system clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `sw_raw_i`  in  SW_W: asynchronous switch pins.
- `btn_raw_i`  in  4: asynchronous button pins.
- `io_sw_o`  out  32: conditioned switches, zero-extended above `SW_W`. Feeds LSU `io_sw_i`.
- `io_btn_o`  out  4: debounced buttons, 1 = pressed. Feeds LSU `io_btn_i`.
- `btn_press_o`  out  4: one-cycle pulse per button on each debounced press.

## Operation
- Synchroniser: two flops per input bit. Button bits are XOR'd with `BTN_ACTIVE_LOW` after the second flop, so that `s` = 1 means pressed.
- Per-button debouncer state: stable bit `q` and counter `c`. Counter width is `$clog2(DEBOUNCE_CYCLES)`. On each cycle:
  - If `s == q`: `c <= 0`.
  - If `s != q` and `c == DEBOUNCE_CYCLES-1`: `q <= s`, `c <= 0`.
  - Otherwise: `c <= c+1`.
- States per bit: STABLE (`c == 0`, `s == q`) and PENDING (`s != q`). A PENDING bit returns to STABLE either when the input reverts (counter cleared, `q` unchanged) or when it commits (`q` flips).
- Glitch rejection: any deviation lasting fewer than `DEBOUNCE_CYCLES` synchronised cycles leaves `q` unchanged. A bounce restarts the count from 0.
- Press pulse: `btn_press_o[i]` is registered. It is 1 for exactly the cycle in which `io_btn_o[i]` first reads 1 after a 0→1 commit. Releases produce no pulse.
- Buttons are independent. Simultaneous presses of several buttons give simultaneous pulses.
- `io_sw_o[31:SW_W]` is constant 0.
- `io_btn_o` is `q`, taken directly from the flops with no combinational logic.

## Timing
- Reset values (asynchronous, immediate on `rst_ni` low):
  - Switch synchroniser flops: 0.
  - Button synchroniser flops: `BTN_ACTIVE_LOW`, i.e. the released level.
  - All `q`: 0. All counters: 0.
  - Outputs: `io_sw_o` = 0, `io_btn_o` = 0, `btn_press_o` = 0.
- Button latency: a raw edge sampled at clock edge 0 and held steady appears on `io_btn_o` after rising edge `DEBOUNCE_CYCLES+2`. The pulse appears at the same edge.
- Switch latency without the macro: 2 cycles.
- Reset asserted mid-count discards the pending transition. After release, a held-pressed button takes the full `DEBOUNCE_CYCLES+2` to commit and does produce a pulse.
- A counter never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.

## Configuration
- `IO_SW_DEBOUNCE_EN`:
  - Defined: each of the `SW_W` switch bits gets its own `q`/`c` debouncer, identical to the buttons. Switch latency becomes `DEBOUNCE_CYCLES+2`. Switches have no press pulse.
  - Undefined: switches are only double-flopped, with 2-cycle latency and no counters instantiated.
- Button behaviour is identical in both builds.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 8, `SW_W` = 18, `BTN_ACTIVE_LOW` = 1.
1. Reset: hold `rst_ni` = 0 with `btn_raw_i` = 4'h0 and `sw_raw_i` = 18'h3FFFF → all outputs stay 0 during reset.
2. Clean press: drive `btn_raw_i` 4'hF→4'hE and hold → `io_btn_o` = 4'h1 after exactly 10 edges. `btn_press_o` = 4'h1 for one cycle only. Releasing to 4'hF → `io_btn_o` = 0 after 10 edges, with no pulse.
3. Bounce: toggle `btn_raw_i[1]` low 5 cycles, high 2 cycles, then low steady → no change on `io_btn_o` until 10 edges after the final fall. Exactly one pulse of 4'h2.
4. Glitch: drive `btn_raw_i[2]` low for 7 cycles, then high → `io_btn_o` stays 0 and `btn_press_o` never asserts.
5. Switches without the macro: `sw_raw_i` = 18'h2A5A5 → `io_sw_o` = 32'h0002A5A5 two edges later, with bits 31:18 = 0. With `IO_SW_DEBOUNCE_EN` → the same value after 10 edges, and a 3-cycle glitch is rejected.
6. Reset mid-count: press `btn_raw_i[3]`, assert `rst_ni` after 5 cycles, release reset with the button still held → commit occurs 10 edges after reset release, and `btn_press_o` = 4'h8 pulses once.
